// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer - start detect, mid-bit sampling, valid/ack word output, sticky errors.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
  parameter int W_WORD     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic              rx_ack,
  input  logic              err_clr,
  output logic [W_WORD-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(W_WORD);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(W_WORD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [W_WORD-1:0] shift_q, shift_d;
  logic              armed_q, armed_d;
  logic              rx_m, rx_s;
  logic              word_done, frame_ev;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latches).
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    word_done = 1'b0;
    frame_ev  = 1'b0;
    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (rx_s) armed_d = 1'b1;
          else if (armed_q) state_d = START;
        end
        START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[W_WORD-1:1]};
            if (bcnt_q == B_LAST) begin
              bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = IDLE;
            if (rx_s) begin
              word_done = 1'b1;
            end else begin
              frame_ev = 1'b1;
              armed_d  = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      if (word_done) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      // A same-cycle error event overrides err_clr.
      frame_err <= frame_ev | (frame_err & ~err_clr);
      overrun   <= (word_done & rx_valid & ~rx_ack) | (overrun & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_ev;
  assign par_ev = baud_tick && (state_q == PARITY) && (tcnt_q == T_LAST) && ((^shift_q) ^ rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= par_ev | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state_q != IDLE);

endmodule
